// File: rtl/program_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into
// 32-bit words, writes them at consecutive word addresses and holds the CPU in reset meanwhile.
module program_loader #(
   parameter int MEMORY_DEPTH = 32,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [DATA_WIDTH-1:0] NumWords,
   input  logic                  ByteValid,
   input  logic [7:0]            ByteData,
   output logic                  ByteReady,
   output logic                  MemWrite,
   output logic [DATA_WIDTH-1:0] WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  Busy,
   output logic                  CpuHold,
   output logic                  Done,
   output logic [DATA_WIDTH-1:0] Checksum
);

   // state    | meaning
   // ST_IDLE  | after reset, waiting for Start
   // ST_LOAD  | collecting the four bytes of the current word
   // ST_WRITE | one-cycle write strobe to the program memory
   // ST_DONE  | requested words written, CPU released

   localparam int CW = $clog2(MEMORY_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t         state;
   logic [CW-1:0]  target;
   logic [CW-1:0]  word_cnt;
   logic [1:0]     byte_idx;
   logic [CW-1:0]  clamped;

   always_comb begin
      clamped = NumWords[CW-1:0];
      if (NumWords > DATA_WIDTH'(MEMORY_DEPTH))
         clamped = CW'(MEMORY_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         target       <= '0;
         word_cnt     <= '0;
         byte_idx     <= '0;
         WriteAddress <= '0;
         WriteData    <= '0;
         Checksum     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  target       <= clamped;
                  word_cnt     <= '0;
                  byte_idx     <= '0;
                  WriteAddress <= '0;
                  WriteData    <= '0;
                  Checksum     <= '0;
                  state        <= (clamped != '0) ? ST_LOAD : ST_DONE;
               end
            end
            ST_LOAD: begin
               if (ByteValid) begin
                  WriteData[8*byte_idx +: 8] <= ByteData;
                  byte_idx                   <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3)
                     state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               Checksum     <= Checksum ^ WriteData;
               word_cnt     <= word_cnt + CW'(1);
               WriteAddress <= WriteAddress + DATA_WIDTH'(4);
               byte_idx     <= '0;
               state        <= (word_cnt + CW'(1) == target) ? ST_DONE : ST_LOAD;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake and status outputs decode straight from the state register, so
   // nothing combinational reaches them from ByteValid.
   assign ByteReady = (state == ST_LOAD);
   assign MemWrite  = (state == ST_WRITE);
   assign Busy      = (state == ST_LOAD) || (state == ST_WRITE);
   assign CpuHold   = Busy;
   assign Done      = (state == ST_DONE);

endmodule
